// File: rtl/g_gate_pkg.sv
// Shared gate-library definitions: MODE encodings and the N-input reduction helper
// used by the registered gate macros.
package g_gate_pkg;

  localparam logic [1:0] G_MODE_NOR  = 2'b00;
  localparam logic [1:0] G_MODE_OR   = 2'b01;
  localparam logic [1:0] G_MODE_NAND = 2'b10;
  localparam logic [1:0] G_MODE_AND  = 2'b11;

  // Widest channel the reduction helper supports; callers zero-extend into this.
  localparam int unsigned G_MAX_N = 64;

  typedef logic [G_MAX_N-1:0] g_vec_t;

  // Reduce the low n bits of v by the selected function.
  function automatic logic g_mode_fn(input logic [1:0] mode, input g_vec_t v,
                                     input int unsigned n);
    logic any_one;
    logic all_one;
    logic res;
    any_one = 1'b0;
    all_one = 1'b1;
    for (int unsigned i = 0; i < G_MAX_N; i++) begin
      if (i < n) begin
        any_one = any_one | v[i];
        all_one = all_one & v[i];
      end
    end
    unique case (mode)
      G_MODE_NOR:  res = ~any_one;
      G_MODE_OR:   res = any_one;
      G_MODE_NAND: res = ~all_one;
      G_MODE_AND:  res = all_one;
      default:     res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/g_nor_flt_if.sv
// Channel bus of the g_nor_flt gate block: enable, function select, inputs and
// the registered results with their change strobes.
interface g_nor_flt_if #(
  parameter int unsigned CH = 4,
  parameter int unsigned N  = 2
);

  logic            en;
  logic [1:0]      mode;
  logic [CH*N-1:0] a;
  logic [CH-1:0]   yn;
  logic [CH-1:0]   chg;

  modport master (
    output en,
    output mode,
    output a,
    input  yn,
    input  chg
  );

  modport slave (
    input  en,
    input  mode,
    input  a,
    output yn,
    output chg
  );

endinterface

// File: rtl/g_glitch_flt.sv
// One channel of the output stage: stability filter (G_NOR_FLT_FILTER_EN defined)
// or a plain register, producing YN and its one-cycle change strobe.
module g_glitch_flt #(
  parameter int unsigned FILT = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic r_i,
  output logic yn_o,
  output logic chg_o
);

  logic yn_d, yn_q;
  logic chg_d, chg_q;

  if (FILT < 1) begin : g_bad_filt
    $error("g_glitch_flt: FILT must be >= 1");
  end

`ifdef G_NOR_FLT_FILTER_EN
  localparam int unsigned CntW = (FILT > 1) ? $clog2(FILT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(FILT - 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  // A new value must differ from YN for FILT consecutive enabled cycles; any
  // agreeing cycle restarts qualification.
  always_comb begin
    cnt_d = cnt_q;
    yn_d  = yn_q;
    chg_d = 1'b0;
    if (en_i) begin
      if (r_i == yn_q) begin
        cnt_d = '0;
      end else if (cnt_q == CntMax) begin
        yn_d  = r_i;
        cnt_d = '0;
        chg_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  always_comb begin
    yn_d  = en_i ? r_i : yn_q;
    chg_d = en_i & (r_i ^ yn_q);
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      yn_q  <= 1'b0;
      chg_q <= 1'b0;
    end else begin
      yn_q  <= yn_d;
      chg_q <= chg_d;
    end
  end

  assign yn_o  = yn_q;
  assign chg_o = chg_q;

endmodule

// File: rtl/g_nor_flt.sv
// CH-channel registered NOR/OR/NAND/AND gate with optional per-channel stability
// filter (enabled by defining G_NOR_FLT_FILTER_EN) and change strobes.
module g_nor_flt
  import g_gate_pkg::*;
#(
  parameter int unsigned CH   = 4,
  parameter int unsigned N    = 2,
  parameter int unsigned FILT = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  g_nor_flt_if.slave bus
);

  if (N < 2) begin : g_bad_n
    $error("g_nor_flt: N must be >= 2");
  end
  if (N > G_MAX_N) begin : g_big_n
    $error("g_nor_flt: N exceeds G_MAX_N");
  end
  if (CH < 1) begin : g_bad_ch
    $error("g_nor_flt: CH must be >= 1");
  end
  if (FILT < 1) begin : g_bad_filt
    $error("g_nor_flt: FILT must be >= 1");
  end

  logic [CH-1:0] r_fn;
  logic [CH-1:0] r_d, r_q;
  logic [CH-1:0] yn;
  logic [CH-1:0] chg;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    assign r_fn[c] = g_mode_fn(bus.mode, G_MAX_N'(bus.a[c*N +: N]), N);

    g_glitch_flt #(
      .FILT (FILT)
    ) u_flt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (bus.en),
      .r_i    (r_q[c]),
      .yn_o   (yn[c]),
      .chg_o  (chg[c])
    );
  end

  always_comb begin
    r_d = bus.en ? r_fn : r_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_q <= '0;
    end else begin
      r_q <= r_d;
    end
  end

  assign bus.yn  = yn;
  assign bus.chg = chg;

endmodule

// File: tb/tb_g_nor_flt.sv
// Scoreboard bench for g_nor_flt (CH=4, N=2, FILT=4); follows G_NOR_FLT_FILTER_EN.
module tb_g_nor_flt;

  localparam int unsigned CH   = 4;
  localparam int unsigned N    = 2;
  localparam int unsigned FILT = 4;
`ifdef G_NOR_FLT_FILTER_EN
  localparam int unsigned FE = FILT;
`else
  localparam int unsigned FE = 1;
`endif
  localparam int unsigned LAT = 1 + FE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  g_nor_flt_if #(.CH(CH), .N(N)) bus ();

  g_nor_flt #(
    .CH   (CH),
    .N    (N),
    .FILT (FILT)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [CH-1:0] m_r, m_yn, m_chg;
  int            m_cnt [CH];
  logic [7:0]    sb [$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic m_fn(input logic [1:0] mode, input logic [1:0] v);
    case (mode)
      2'b00:   return ~(v[0] | v[1]);
      2'b01:   return v[0] | v[1];
      2'b10:   return ~(v[0] & v[1]);
      default: return v[0] & v[1];
    endcase
  endfunction

  task automatic step(input logic en, input logic [1:0] mode, input logic [7:0] a);
    logic [CH-1:0] nr;
    logic [7:0]    e;
    bus.en   = en;
    bus.mode = mode;
    bus.a    = a;
    for (int c = 0; c < CH; c++) begin
      nr[c]    = en ? m_fn(mode, a[c*2 +: 2]) : m_r[c];
      m_chg[c] = 1'b0;
      if (en) begin
        if (m_r[c] == m_yn[c]) begin
          m_cnt[c] = 0;
        end else if (m_cnt[c] == int'(FE) - 1) begin
          m_yn[c]  = m_r[c];
          m_cnt[c] = 0;
          m_chg[c] = 1'b1;
        end else begin
          m_cnt[c]++;
        end
      end
    end
    m_r = nr;
    sb.push_back({m_yn, m_chg});
    @(posedge clk);
    #1;
    check_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_eq("yn", 32'(bus.yn), 32'(e[7:4]));
      check_eq("chg", 32'(bus.chg), 32'(e[3:0]));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_r   = '0;
    m_yn  = '0;
    m_chg = '0;
    for (int c = 0; c < CH; c++) m_cnt[c] = 0;
    #1;
    check_eq("rst_yn", 32'(bus.yn), 32'd0);
    check_eq("rst_chg", 32'(bus.chg), 32'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check_eq("rst_hold_yn", 32'(bus.yn), 32'd0);
      check_eq("rst_hold_chg", 32'(bus.chg), 32'd0);
    end
    rst_n = 1'b1;
  endtask

  logic [11:0] mode_tbl;
  logic [5:0]  pat_tbl;

  initial begin
    bus.en   = 1'b1;
    bus.mode = 2'b00;
    bus.a    = '0;
    #2;
    do_reset();

    // Release: steady NOR of zeros reaches all-ones after the full latency.
    for (int i = 1; i <= int'(LAT); i++) begin
      step(1'b1, 2'b00, 8'h00);
      if (i == int'(LAT) - 1) check_eq("lat_early_yn", 32'(bus.yn), 32'h0);
    end
    check_eq("lat_yn", 32'(bus.yn), 32'hF);
    check_eq("lat_chg", 32'(bus.chg), 32'hF);
    repeat (3) step(1'b1, 2'b00, 8'h00);

    // Short glitch on channel 0.
    repeat (3) step(1'b1, 2'b00, 8'h01);
    repeat (8) step(1'b1, 2'b00, 8'h00);
`ifdef G_NOR_FLT_FILTER_EN
    check_eq("glitch_yn0", 32'(bus.yn[0]), 32'd1);
`endif

    // Qualified change on channel 0.
    repeat (int'(LAT)) step(1'b1, 2'b00, 8'h01);
    check_eq("qual_yn", 32'(bus.yn), 32'hE);
    repeat (3) step(1'b1, 2'b00, 8'h01);

    // Mode table on channel 1: patterns 10, 11, 00.
    mode_tbl = {3'b010, 3'b101, 3'b110, 3'b001};  // AND, NAND, OR, NOR (pattern 0 in MSB)
    pat_tbl  = {2'b10, 2'b11, 2'b00};
    for (int m = 0; m < 4; m++) begin
      for (int p = 0; p < 3; p++) begin
        repeat (int'(LAT) + 2) step(1'b1, 2'(m), {4'h0, pat_tbl[5-2*p -: 2], 2'b00});
        check_eq("mode_yn1", 32'(bus.yn[1]), 32'(mode_tbl[m*3 + 2 - p]));
      end
    end

    // Enable stall in the middle of qualification.
    repeat (int'(LAT) + 2) step(1'b1, 2'b00, 8'h00);
    repeat (3) step(1'b1, 2'b00, 8'h01);
    repeat (6) step(1'b0, 2'b00, 8'h00);
    repeat (int'(LAT) + 2) step(1'b1, 2'b00, 8'h01);

    // Reset mid-qualification, then a fresh qualification.
    repeat (2) step(1'b1, 2'b00, 8'h00);
    do_reset();
    repeat (int'(LAT) + 2) step(1'b1, 2'b00, 8'h00);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3) == 0 ? $urandom_range(0, 3)
           : 32'(bus.mode)), 8'($urandom_range(0, 255)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
